dff_mux_sel_arb: RTL
====================

DFF_MUX_SEL_ARB -- requirements
Module: dff_mux_sel_arb

Interface
REQ-001 The block SHALL have parameter HOLD_W, default 4, giving the width of the hold-length input and the internal hold counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req1, input, 1 bit: source 1 (mux data input x1) requests the registered 2:1 mux.
REQ-005 The block SHALL have port req2, input, 1 bit: source 2 (mux data input x2) requests the registered 2:1 mux.
REQ-006 The block SHALL have port hold_len, input, HOLD_W bits: extra cycles a grant is held beyond the first; sampled every cycle.
REQ-007 The block SHALL have port s, output, 1 bit, registered: select driven into the downstream dff_mux_2x1; 0 selects x1, 1 selects x2.
REQ-008 The block SHALL have port gnt1, output, 1 bit, registered: source 1 currently granted.
REQ-009 The block SHALL have port gnt2, output, 1 bit, registered: source 2 currently granted.
REQ-010 The block SHALL have port busy, output, 1 bit, registered: equals gnt1 | gnt2.
REQ-011 The block SHALL have port sw_cnt, output, 8 bits, registered: count of changes of s, wrapping 255 -> 0.

Function
REQ-012 The FSM SHALL have three states: IDLE (gnt1=0, gnt2=0), G1 (gnt1=1, s=0), G2 (gnt2=1, s=1); at most one grant is high in any cycle.
REQ-013 Grants SHALL be registered: a request sampled at edge N produces a grant at edge N, visible after edge N, i.e. one cycle latency from request to grant.
REQ-014 An internal last-winner flag SHALL record the most recently granted source; when both request, the source other than the last winner wins (round-robin).
REQ-015 In IDLE: req1 only -> G1; req2 only -> G2; both -> round-robin per REQ-014; neither -> stay IDLE.
REQ-016 In IDLE, s SHALL hold its previous value, so the downstream mux keeps the last selected source.
REQ-017 In Gx, the hold counter SHALL increment each cycle the grant is held, and SHALL clear to 0 on every entry into G1 or G2 and on every re-grant.
REQ-018 In Gx, if req_x is low, the next state SHALL be the other grant if the other source requests, else IDLE; this check takes priority over the hold count.
REQ-019 In Gx with req_x high and counter == hold_len: if the other source requests, switch to the other grant; otherwise re-grant the same source with the counter cleared.
REQ-020 In Gx with req_x high and counter < hold_len, the FSM SHALL stay in Gx.
REQ-021 With hold_len = 0, each grant SHALL last exactly one cycle before re-arbitration; under constant req1 = req2 = 1, s SHALL toggle every cycle.
REQ-022 If hold_len is lowered below the current count mid-grant, the comparison SHALL be treated as expiry (counter >= hold_len).
REQ-023 The hold counter SHALL NOT wrap; maximum hold is 2^HOLD_W cycles per grant.
REQ-024 sw_cnt SHALL increment by 1 on every edge where the registered s changes value, and SHALL wrap modulo 256.
REQ-025 A G1 <-> G2 switch SHALL occur directly with no IDLE cycle between the grants.

Reset
REQ-026 While rst_n = 0, the block SHALL immediately force: state IDLE, s=0, gnt1=0, gnt2=0, busy=0, sw_cnt=0, counter=0, last-winner=source 2 (so source 1 wins the first contention).
REQ-027 Reset asserted mid-grant SHALL drop the grant asynchronously without waiting for a clock edge; the first grant after release follows REQ-015.
REQ-028 Deassertion of rst_n SHALL take effect at the next rising clk edge.

Verification
REQ-029 The bench SHALL cover: reset, then req1=req2=1 with hold_len=2 -> gnt1 for 3 cycles (s=0), then gnt2 for 3 cycles (s=1), alternating; sw_cnt +1 per switch.
REQ-030 The bench SHALL cover: req2 only, hold_len=0 -> gnt2 re-granted every cycle, s=1 steady, sw_cnt=1 after the first grant, then unchanged.
REQ-031 The bench SHALL cover: in G1, drop req1 at count 1 while req2=1 -> next cycle gnt2=1, gnt1=0, no IDLE cycle.
REQ-032 The bench SHALL cover: all requests drop -> IDLE, busy=0, s keeps its last value (1 after a G2 grant).
REQ-033 The bench SHALL cover: rst_n pulsed low mid-G2 -> gnt2, s and busy go to 0 before the next edge; after release, req1=req2=1 -> gnt1 first.
REQ-034 The bench SHALL cover: hold_len=0 with both requesting for 300 cycles -> sw_cnt wraps past 255 to a correct modulo-256 value.

Source files
------------

// File: rtl/dff_mux_sel_arb.sv
// dff_mux_sel_arb: round-robin arbiter with hold counter driving a registered 2:1 mux select
module dff_mux_sel_arb #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic              req2,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              s,
  output logic              gnt1,
  output logic              gnt2,
  output logic              busy,
  output logic [7:0]        sw_cnt
);
  typedef enum logic [1:0] {IDLE, G1, G2} state_t;
  state_t state_q, state_d, arb, oth;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic last_q, last_d, s_q, s_d, gnt1_q, gnt2_q, busy_q, own, other, keep;
  logic [7:0] sw_q;
  assign s      = s_q;
  assign gnt1   = gnt1_q;
  assign gnt2   = gnt2_q;
  assign busy   = busy_q;
  assign sw_cnt = sw_q;
  // next-state: arbitration from IDLE, release/expiry handling while granted
  always_comb begin
    arb     = (req1 & req2) ? (last_q ? G1 : G2) : req1 ? G1 : req2 ? G2 : IDLE;
    own     = (state_q == G1) ? req1 : req2;
    other   = (state_q == G1) ? req2 : req1;
    oth     = (state_q == G1) ? G2 : G1;
    keep    = own & (cnt_q < hold_len);
    state_d = (state_q == IDLE) ? arb :
              !own ? (other ? oth : IDLE) :
              keep ? state_q : (other ? oth : state_q);
    cnt_d   = (state_q != IDLE && keep) ? cnt_q + 1'b1 : '0;
    last_d  = (state_d == G1) ? 1'b0 : (state_d == G2) ? 1'b1 : last_q;
    s_d     = (state_d == G1) ? 1'b0 : (state_d == G2) ? 1'b1 : s_q;
  end
  // state and registered outputs; last winner resets to source 2 so source 1 wins first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      busy_q  <= 1'b0;
      sw_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      s_q     <= s_d;
      gnt1_q  <= (state_d == G1);
      gnt2_q  <= (state_d == G2);
      busy_q  <= (state_d != IDLE);
      sw_q    <= sw_q + {7'd0, s_d != s_q};
    end
  end
endmodule
